// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: control handshake and memory-controller bus of matmul_sequencer (start/busy/done, address/write_en/DATA out, Q in)
interface matmul_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        write_en;
  logic [15:0] address;
  logic [31:0] DATA;
  logic [31:0] Q;
  modport master (input start, Q, output busy, done, address, write_en, DATA);
  modport slave (output start, Q, input busy, done, address, write_en, DATA);
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: sequences C = A x B for N x N byte matrices over a 1-cycle-latency memory controller (ports clk, reset, bus.master: start/busy/done/address/write_en/DATA/Q); define MATMUL_SIGNED_EN for signed operands
module matmul_sequencer #(
  parameter int          N      = 4,
  parameter logic [11:0] A_BASE = 12'h000,
  parameter logic [11:0] B_BASE = 12'h000,
  parameter logic [11:0] C_BASE = 12'h000
) (
  input logic                clk,
  input logic                reset,
  matmul_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, WR_C, DONE} state_t;
  localparam logic [2:0]  LAST = 3'(N - 1);
  localparam logic [11:0] NW   = 12'(N);
  state_t      state, nxt;
  logic [2:0]  i, j, k;
  logic [7:0]  a;
  logic [15:0] p;
  logic [31:0] acc, prod;
  logic [11:0] a_addr, b_addr, c_addr;
  assign a_addr = A_BASE + {9'h0, i} * NW + {9'h0, k};
  assign b_addr = B_BASE + {9'h0, k} * NW + {9'h0, j};
  assign c_addr = C_BASE + {9'h0, i} * NW + {9'h0, j};
`ifdef MATMUL_SIGNED_EN
  assign p    = {{8{a[7]}}, a} * {{8{bus.Q[7]}}, bus.Q[7:0]};
  assign prod = {{16{p[15]}}, p};
`else
  assign p    = {8'h0, a} * {8'h0, bus.Q[7:0]};
  assign prod = {16'h0, p};
`endif
  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE:    nxt = bus.start ? RD_A : IDLE;
      RD_A:    nxt = RD_B;
      RD_B:    nxt = MAC;
      MAC:     nxt = k < LAST ? RD_A : WR_C;
      WR_C:    nxt = (j < LAST || i < LAST) ? RD_A : DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    bus.busy     = state != IDLE;
    bus.done     = state == DONE;
    bus.write_en = state == WR_C;
    bus.DATA     = state == WR_C ? acc : '0;
    bus.address  = state == RD_A ? {4'h0, a_addr} :
                   state == RD_B ? {4'h1, b_addr} :
                   state == WR_C ? {4'h2, c_addr} : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      a     <= '0;
      acc   <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (bus.start) begin
          i   <= '0;
          j   <= '0;
          k   <= '0;
          acc <= '0;
        end
        RD_B: a <= bus.Q[7:0];
        MAC: begin
          acc <= acc + prod;
          if (k < LAST) k <= k + 3'd1;
        end
        WR_C: begin
          acc <= '0;
          k   <= '0;
          if (j < LAST) j <= j + 3'd1;
          else if (i < LAST) begin
            j <= '0;
            i <= i + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: randomized self-checking bench for matmul_sequencer with N=4/2/1 instances, memory model and arithmetic reference
module tb_matmul_sequencer;
  localparam int          NS [3] = '{4, 2, 1};
  localparam logic [11:0] AB [3] = '{12'h010, 12'h000, 12'h000};
  localparam logic [11:0] BB [3] = '{12'h040, 12'h000, 12'h000};
  localparam logic [11:0] CB [3] = '{12'h080, 12'h000, 12'h000};
  logic clk = 0;
  logic reset = 1;
  logic start_v [3];
  logic busy_v [3];
  logic done_v [3];
  logic we_v [3];
  logic [15:0] addr_v [3];
  logic [31:0] data_v [3];
  logic [31:0] mem [3][4][256];
  int wcnt [3] = '{0, 0, 0};
  int dcnt [3] = '{0, 0, 0};
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] a_m [8][8];
  logic [7:0] b_m [8][8];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    matmul_sequencer_if bus ();
    matmul_sequencer #(.N(NS[g]), .A_BASE(AB[g]), .B_BASE(BB[g]), .C_BASE(CB[g])) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
    );
    assign bus.start = start_v[g];
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign we_v[g]   = bus.write_en;
    assign addr_v[g] = bus.address;
    assign data_v[g] = bus.DATA;
    always @(posedge clk) begin
      bus.Q <= mem[g][bus.address[13:12]][bus.address[7:0]];
      if (bus.write_en) mem[g][bus.address[13:12]][bus.address[7:0]] <= bus.DATA;
      if (bus.write_en) wcnt[g] <= wcnt[g] + 1;
      if (bus.done) dcnt[g] <= dcnt[g] + 1;
    end
  end
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ((!we_v[g] && data_v[g] !== 32'h0) || ((!busy_v[g] || done_v[g]) && (addr_v[g] !== 16'h0 || we_v[g] !== 1'b0))) begin
        n_fail++;
        $display("FAIL bus_quiet inst%0d: busy=%b done=%b write_en=%b address=%h DATA=%h, required DATA=0 without write_en and address=0,write_en=0 in IDLE/DONE",
                 g, busy_v[g], done_v[g], we_v[g], addr_v[g], data_v[g]);
      end
    end
  end
  function automatic int ext(input logic [7:0] x);
`ifdef MATMUL_SIGNED_EN
    logic signed [7:0] s = x;
    return int'(s);
`else
    return int'({24'h0, x});
`endif
  endfunction
  function automatic logic [31:0] exp_c(input int n, input int r, input int c);
    logic [31:0] s = 0;
    for (int t = 0; t < n; t++) s += 32'(ext(a_m[r][t]) * ext(b_m[t][c]));
    return s;
  endfunction
  task automatic load(input int g, input int mode);
    int n = NS[g];
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        a_m[r][c] = mode == 0 ? 8'(r == c) : (mode == 1 || mode == 2) ? 8'hFF : mode == 4 ? 8'h03 : 8'($urandom);
        b_m[r][c] = mode == 0 ? 8'(r * n + c) : mode == 1 ? 8'hFF : mode == 2 ? 8'h01 : mode == 4 ? 8'h05 : 8'($urandom);
        mem[g][0][8'(int'(AB[g]) + r * n + c)] = {24'($urandom), a_m[r][c]};
        mem[g][1][8'(int'(BB[g]) + r * n + c)] = {24'($urandom), b_m[r][c]};
        mem[g][2][8'(int'(CB[g]) + r * n + c)] = 32'hDEADBEEF;
      end
  endtask
  task automatic pulse_start(input int g);
    @(negedge clk) start_v[g] = 1;
    @(negedge clk) start_v[g] = 0;
  endtask
  task automatic run_op(input int g, output int lat, output int nw, output int nd);
    int w0 = wcnt[g];
    int d0 = dcnt[g];
    pulse_start(g);
    lat = -1;
    for (int m = 1; m <= 3000; m++) begin
      @(negedge clk);
      if (done_v[g]) begin
        lat = m + 1;
        break;
      end
    end
    repeat (4) @(negedge clk);
    nw = wcnt[g] - w0;
    nd = dcnt[g] - d0;
  endtask
  task automatic test_reset();
    reset = 1;
    for (int g = 0; g < 3; g++) start_v[g] = 1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if ({busy_v[g], done_v[g], we_v[g]} !== 3'b000 || addr_v[g] !== 16'h0 || data_v[g] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: busy/done/we=%b%b%b addr=%h data=%h, required all zero", g, busy_v[g], done_v[g], we_v[g], addr_v[g], data_v[g]);
      end
    end
    for (int g = 0; g < 3; g++) start_v[g] = 0;
    @(negedge clk) reset = 0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_checks++;
      if (busy_v[g] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle inst%0d: busy=%b, required 0", g, busy_v[g]);
      end
    end
  endtask
  task automatic test_matrix(input string name, input int g, input int mode);
    int n = NS[g];
    int lat, nw, nd;
    logic [31:0] got;
    load(g, mode);
    run_op(g, lat, nw, nd);
    n_checks++;
    if (lat != n * n * (3 * n + 1) + 1) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, n * n * (3 * n + 1) + 1);
    end
    n_checks++;
    if (nw != n * n) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, required %0d", name, nw, n * n);
    end
    n_checks++;
    if (nd != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d, required 1", name, nd);
    end
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        got = mem[g][2][8'(int'(CB[g]) + r * n + c)];
        n_checks++;
        if (got !== exp_c(n, r, c)) begin
          n_fail++;
          $display("FAIL %s C[%0d][%0d]: got %h, required %h", name, r, c, got, exp_c(n, r, c));
        end
      end
  endtask
  task automatic test_busy_start();
    int w0, d0, cyc;
    bit seen;
    logic [31:0] got;
    load(0, 3);
    w0 = wcnt[0];
    d0 = dcnt[0];
    pulse_start(0);
    repeat (48) @(negedge clk);
    pulse_start(0);
    seen = 0;
    for (int m = 0; m < 400 && !seen; m++) begin
      @(negedge clk);
      seen = done_v[0];
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (dcnt[0] - d0 != 1) begin
      n_fail++;
      $display("FAIL busy_start done_count: got %0d, required 1", dcnt[0] - d0);
    end
    n_checks++;
    if (wcnt[0] - w0 != 16) begin
      n_fail++;
      $display("FAIL busy_start write_count: got %0d, required 16", wcnt[0] - w0);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        got = mem[0][2][8'(int'(CB[0]) + r * 4 + c)];
        n_checks++;
        if (got !== exp_c(4, r, c)) begin
          n_fail++;
          $display("FAIL busy_start C[%0d][%0d]: got %h, required %h", r, c, got, exp_c(4, r, c));
        end
      end
    load(0, 3);
    @(negedge clk) start_v[0] = 1;
    seen = 0;
    cyc = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      seen = done_v[0];
      cyc++;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL held_start done: got no done within 400 cycles, required a pulse");
    end
    @(negedge clk);
    n_checks++;
    if (busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start idle: busy=%b after done, required 0", busy_v[0]);
    end
    @(negedge clk);
    n_checks++;
    if (busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL held_start relaunch: busy=%b, required 1", busy_v[0]);
    end
    start_v[0] = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    int w0, w1, d1, seen;
    load(0, 3);
    w0 = wcnt[0];
    pulse_start(0);
    seen = we_v[0] ? 1 : 0;
    for (int m = 0; m < 1000 && seen < 3; m++) begin
      @(negedge clk);
      if (we_v[0]) seen++;
    end
    n_checks++;
    if (seen != 3) begin
      n_fail++;
      $display("FAIL reset_mid third_write: saw %0d write pulses, required 3", seen);
    end
    reset = 1;
    @(negedge clk);
    n_checks++;
    if (busy_v[0] !== 1'b0 || we_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid abort: busy=%b write_en=%b, required 0 0", busy_v[0], we_v[0]);
    end
    reset = 0;
    w1 = wcnt[0];
    d1 = dcnt[0];
    n_checks++;
    if (w1 - w0 != 3) begin
      n_fail++;
      $display("FAIL reset_mid writes_before: got %0d, required 3", w1 - w0);
    end
    repeat (300) @(negedge clk);
    n_checks++;
    if (wcnt[0] != w1 || dcnt[0] != d1) begin
      n_fail++;
      $display("FAIL reset_mid quiet: got %0d writes %0d dones after reset, required 0 0", wcnt[0] - w1, dcnt[0] - d1);
    end
    test_matrix("after_reset", 0, 3);
  endtask
  initial begin
    for (int g = 0; g < 3; g++) begin
      start_v[g] = 0;
      for (int b = 0; b < 4; b++)
        for (int w = 0; w < 256; w++) mem[g][b][w] = 32'h0;
    end
    test_reset();
    test_matrix("identity", 0, 0);
    test_matrix("all_ones", 0, 1);
    test_matrix("signed_n2", 1, 2);
    test_matrix("edge_n1", 2, 4);
    repeat (3) test_matrix("random_n4", 0, 3);
    repeat (3) test_matrix("random_n2", 1, 3);
    repeat (3) test_matrix("random_n1", 2, 3);
    test_busy_start();
    test_reset_mid();
    test_matrix("back_to_back", 0, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The block SHALL expose parameters (name, default, meaning):
- N, 4, matrix dimension, legal range 1..8.
- A_BASE, 12'h000, word offset of matrix A in DM1.
- B_BASE, 12'h000, word offset of matrix B in DM2.
- C_BASE, 12'h000, word offset of matrix C in DM3.

REQ-002 The block SHALL expose ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, request one multiply.
- busy, out, 1, operation in progress.
- done, out, 1, one-cycle completion pulse.
- address, out, 16, {select nibble, 12-bit word address} to the memory controller.
- write_en, out, 1, write strobe to the memory controller.
- DATA, out, 32, write data to the memory controller.
- Q, in, 32, read data from the memory controller.

REQ-003 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 The block SHALL compute C = A x B for N x N matrices:
- A[i][k] is Q[7:0] read at address {4'h0, A_BASE+i*N+k}.
- B[k][j] is Q[7:0] read at address {4'h1, B_BASE+k*N+j}.
- C[i][j] is written as a full 32-bit word at address {4'h2, C_BASE+i*N+j}.

REQ-005 Memory read latency SHALL be exactly 1 cycle: Q is sampled in the cycle after the address is driven.

REQ-006 The FSM SHALL have states IDLE, RD_A, RD_B, MAC, WR_C and DONE.

REQ-007 IDLE SHALL go to RD_A when start=1. Loop indices i, j and k and the accumulator SHALL clear on this transition.

REQ-008 RD_A SHALL drive the A address, then go to RD_B.

REQ-009 RD_B SHALL drive the B address, capture A from Q, then go to MAC.

REQ-010 MAC SHALL capture B from Q and add A*B to the accumulator.
- If k<N-1: increment k and go to RD_A.
- Otherwise: go to WR_C.

REQ-011 WR_C SHALL assert write_en for exactly one cycle with DATA = final accumulator, then clear the accumulator and k.
- If j<N-1: increment j and go to RD_A.
- Else if i<N-1: clear j, increment i and go to RD_A.
- Otherwise: go to DONE.

REQ-012 DONE SHALL assert done for one cycle, then go to IDLE.

REQ-013 Element order SHALL be row-major: j is the inner loop, i the outer loop.

REQ-014 Each C element SHALL take 3N+1 cycles. Total time from the start-sampling edge to the done pulse SHALL be N*N*(3N+1)+1 cycles.

REQ-015 Products SHALL be 16 bits and accumulation 32 bits. For N<=8 no overflow can occur; any sum beyond 32 bits SHALL wrap modulo 2^32.

REQ-016 busy SHALL be 1 in every state except IDLE.

REQ-017 start SHALL be ignored while busy=1. A start held across done SHALL launch a new operation only when sampled in IDLE.

REQ-018 write_en SHALL be 0 in every state except WR_C. address SHALL be 16'h0000 in IDLE and DONE.

REQ-019 DATA SHALL be 0 whenever write_en=0.

Reset
REQ-020 On reset the FSM SHALL enter IDLE, and busy, done, write_en, address, DATA, the accumulator and all indices SHALL be 0.

REQ-021 Reset asserted mid-operation SHALL abort immediately: no further write_en pulse, and no done pulse for the aborted operation.

REQ-022 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-023 When MATMUL_SIGNED_EN is defined, A and B bytes SHALL be two's-complement signed. Products SHALL be sign-extended to 32 bits before accumulation.

REQ-024 Without MATMUL_SIGNED_EN, operands SHALL be unsigned and zero-extended.

Verification
REQ-025 Identity test: N=4, A=identity, B[k][j]=k*4+j, start pulse.
- DM3 words 0..15 SHALL equal 0..15.
- done SHALL pulse exactly 209 cycles after the start edge.

REQ-026 All-ones test: N=4, all A and B bytes 8'hFF, unsigned build.
- Every C word SHALL be 32'h0003F804.

REQ-027 Signed test: MATMUL_SIGNED_EN defined, N=2, A=all 8'hFF, B=all 8'h01.
- Every C word SHALL be 32'hFFFFFFFE.

REQ-028 Start while busy: assert start again at cycle 50 of an operation.
- Exactly one done pulse SHALL occur.
- Exactly 16 write_en pulses SHALL occur.

REQ-029 Reset mid-operation: assert reset during the 3rd WR_C.
- The next cycle SHALL show busy=0 and write_en=0.
- No done pulse SHALL occur.
- A following start SHALL produce a correct full result.

REQ-030 Edge case N=1, A=8'h03, B=8'h05.
- C SHALL be 32'h0000000F.
- Exactly one write_en pulse SHALL occur.
- done SHALL pulse 5 cycles after the start edge.
